// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory address drive and the IF/ID pipeline register.
// The priority order is Redirect, then Flush, then Stall, then normal advance. FetchCount counts valid instructions.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter logic [31:0] NOP      = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] FetchCount
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    count_d   = count_q;
    if (Redirect) begin
      pc_d      = {RedirectPC[31:2], 2'b00};
      instr_d   = NOP;
      pcplus4_d = 32'd0;
      valid_d   = 1'b0;
    end else if (Flush) begin
      // The fetched word is dropped, but the PC still moves past it.
      pc_d      = pc_plus4;
      instr_d   = NOP;
      pcplus4_d = 32'd0;
      valid_d   = 1'b0;
    end else if (!Stall) begin
      pc_d      = pc_plus4;
      instr_d   = IMemInstruction;
      pcplus4_d = pc_plus4;
      valid_d   = 1'b1;
      count_d   = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      pcplus4_q <= 32'd0;
      valid_q   <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  // IMemAddress is taken directly from a register, so control inputs have no combinational path to it.
  assign IMemAddress       = pc_q;
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PCPlus4     = pcplus4_q;
  assign IF_ID_Valid       = valid_q;
  assign FetchCount        = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural PC/IF-ID model is checked on every falling edge,
// and literal expectations pin the key scenarios.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h00400000;
  localparam logic [31:0] NOPW   = 32'h00000000;

  logic        clk;
  logic        reset;
  logic        Stall, Flush, Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] IMemAddress, IMemInstruction;
  logic [31:0] IF_ID_Instruction, IF_ID_PCPlus4, FetchCount;
  logic        IF_ID_Valid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  fetch_stage #(.RESET_PC(RST_PC), .NOP(NOPW)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .IMemAddress(IMemAddress), .IMemInstruction(IMemInstruction),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid), .FetchCount(FetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h00400000) return 32'h20040020;
    return {a[15:0], 16'h0000} ^ a ^ 32'h13579BDF;
  endfunction

  assign IMemInstruction = imem(IMemAddress);

  // Behavioural model: architectural PC plus the IF/ID contents
  logic [31:0] m_pc, m_ins, m_p4, m_cnt;
  logic        m_v;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = RST_PC; m_ins = NOPW; m_p4 = 0; m_v = 0; m_cnt = 0;
    end else if (Redirect) begin
      m_pc = RedirectPC & 32'hFFFFFFFC; m_ins = NOPW; m_p4 = 0; m_v = 0;
    end else if (Flush) begin
      m_pc = m_pc + 4; m_ins = NOPW; m_p4 = 0; m_v = 0;
    end else if (!Stall) begin
      m_ins = imem(m_pc); m_p4 = m_pc + 4; m_pc = m_pc + 4; m_v = 1; m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pc",    IMemAddress,       m_pc);
      chk("model_instr", IF_ID_Instruction, m_ins);
      chk("model_pc4",   IF_ID_PCPlus4,     m_p4);
      chk("model_valid", {31'd0, IF_ID_Valid}, {31'd0, m_v});
      chk("model_count", FetchCount,        m_cnt);
    end
  end

  // Called at a falling edge: apply controls, let one rising edge happen, return at the next falling edge.
  task automatic step(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
    Stall = st; Flush = fl; Redirect = rd; RedirectPC = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},    IMemAddress,       RST_PC);
    chk({tag, "_instr"}, IF_ID_Instruction, NOPW);
    chk({tag, "_pc4"},   IF_ID_PCPlus4,     32'd0);
    chk({tag, "_valid"}, {31'd0, IF_ID_Valid}, 32'd0);
    chk({tag, "_count"}, FetchCount,        32'd0);
  endtask

  logic [2:0]  tbl_ctl [12] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b011, 3'b000,
                                3'b100, 3'b000, 3'b001, 3'b110, 3'b000, 3'b000};
  logic [31:0] tbl_rpc [12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h00001003, 32'h0, 32'h0, 32'h00400102, 32'h0, 32'h0};

  initial begin
    reset = 1'b1; Stall = 0; Flush = 0; Redirect = 0; RedirectPC = 0;
    #1 reset = 1'b0;
    #2 chk_reset_vals("reset");
    cmp_en = 1;
    @(negedge clk);
    reset = 1'b1;

    // First fetch from the reset PC
    step(0, 0, 0, 0);
    chk("f1_instr", IF_ID_Instruction, 32'h20040020);
    chk("f1_pc4",   IF_ID_PCPlus4,     32'h00400004);
    chk("f1_valid", {31'd0, IF_ID_Valid}, 32'd1);
    chk("f1_addr",  IMemAddress,       32'h00400004);
    chk("f1_count", FetchCount,        32'd1);

    step(0, 0, 0, 0);
    chk("adv_addr", IMemAddress, 32'h00400008);

    // Stall for three edges at 0x00400008
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk("stall_addr",  IMemAddress,   32'h00400008);
      chk("stall_pc4",   IF_ID_PCPlus4, 32'h00400008);
      chk("stall_count", FetchCount,    32'd2);
    end
    step(0, 0, 0, 0);
    chk("resume_addr",  IMemAddress,       32'h0040000C);
    chk("resume_instr", IF_ID_Instruction, imem(32'h00400008));
    chk("resume_count", FetchCount,        32'd3);

    step(0, 0, 0, 0);
    chk("pre_flush_addr", IMemAddress, 32'h00400010);

    // Flush beats Stall
    step(1, 1, 0, 0);
    chk("flush_addr",  IMemAddress, 32'h00400014);
    chk("flush_valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("flush_count", FetchCount,  32'd4);

    // Redirect beats Stall, low address bits dropped
    step(1, 0, 1, 32'h00400029);
    chk("redir_addr",  IMemAddress,       32'h00400028);
    chk("redir_valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("redir_instr", IF_ID_Instruction, NOPW);
    chk("redir_count", FetchCount,        32'd4);

    // PC wraps around the top of the address space
    step(0, 0, 1, 32'hFFFFFFFC);
    chk("wrap_pre", IMemAddress, 32'hFFFFFFFC);
    step(0, 0, 0, 0);
    chk("wrap_addr",  IMemAddress,   32'h00000000);
    chk("wrap_pc4",   IF_ID_PCPlus4, 32'h00000000);
    chk("wrap_valid", {31'd0, IF_ID_Valid}, 32'd1);
    chk("wrap_count", FetchCount,    32'd5);

    // Mixed control sequence, checked by the model
    for (int i = 0; i < 12; i++)
      step(tbl_ctl[i][0], tbl_ctl[i][1], tbl_ctl[i][2], tbl_rpc[i]);

    // Asynchronous reset between edges while stalled
    Stall = 1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_vals("areset");
    @(negedge clk);
    step(0, 1, 1, 32'h12345678);
    chk_reset_vals("hold");
    reset = 1'b1; Stall = 0; Flush = 0; Redirect = 0;
    step(0, 0, 0, 0);
    chk("post_instr", IF_ID_Instruction, 32'h20040020);
    chk("post_pc4",   IF_ID_PCPlus4,     32'h00400004);
    chk("post_count", FetchCount,        32'd1);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00400000, SHALL be the PC value loaded on reset.
REQ-002 Parameter NOP, default 32'h00000000, SHALL be the instruction word written into IF/ID for a bubble.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-low (0 = in reset).
REQ-005 Stall  input  1  SHALL request a hold of PC and IF/ID (load-use hazard from decode).
REQ-006 Flush  input  1  SHALL request a bubble into IF/ID (control hazard).
REQ-007 Redirect  input  1  SHALL request a PC load from RedirectPC (taken branch or jump).
REQ-008 RedirectPC  input  32  SHALL be the redirect target byte address.
REQ-009 IMemAddress  output  32  SHALL drive the instruction memory Address port.
REQ-010 IMemInstruction  input  32  SHALL be the word returned combinationally by instruction memory.
REQ-011 IF_ID_Instruction  output  32  SHALL be the registered instruction presented to decode.
REQ-012 IF_ID_PCPlus4  output  32  SHALL be the registered PC+4 of that instruction.
REQ-013 IF_ID_Valid  output  1  SHALL be 1 when IF/ID holds a real instruction, 0 for a bubble.
REQ-014 FetchCount  output  32  SHALL count instructions accepted into IF/ID with Valid=1.

Function
REQ-015 IMemAddress SHALL equal the PC register combinationally; no extra latency.
REQ-016 PC[1:0] SHALL always be 2'b00; RedirectPC[1:0] SHALL be ignored (forced to 00 on load).
REQ-017 Per-edge priority SHALL be: reset > Redirect > Flush > Stall > normal advance.
REQ-018 Normal advance: PC <= PC+4; IF_ID_Instruction <= IMemInstruction; IF_ID_PCPlus4 <= PC+4; IF_ID_Valid <= 1; FetchCount <= FetchCount+1.
REQ-019 Redirect=1: PC <= {RedirectPC[31:2],2'b00}; IF/ID <= bubble (Instruction=NOP, PCPlus4=0, Valid=0); FetchCount unchanged; regardless of Stall or Flush.
REQ-020 Flush=1, Redirect=0: PC <= PC+4; IF/ID <= bubble; FetchCount unchanged; Stall ignored.
REQ-021 Stall=1, Flush=0, Redirect=0: PC, IF/ID and FetchCount SHALL hold their values.
REQ-022 PC+4 SHALL be 32-bit modulo: 32'hFFFFFFFC advances to 32'h00000000, no error flag.
REQ-023 FetchCount SHALL wrap from 32'hFFFFFFFF to 0.
REQ-024 Latency: an instruction at PC SHALL appear on IF_ID_Instruction exactly one edge after PC is presented, unless stalled, flushed or redirected that edge.
REQ-025 The block SHALL contain no combinational path from Stall/Flush/Redirect to IMemAddress.

Reset
REQ-026 On reset=0, asynchronously: PC=RESET_PC, IF_ID_Instruction=NOP, IF_ID_PCPlus4=0, IF_ID_Valid=0, FetchCount=0.
REQ-027 While reset=0, all inputs SHALL be ignored and outputs held at reset values.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation; the first edge after release SHALL fetch from RESET_PC.

Verification
REQ-029 Release reset, Stall/Flush/Redirect=0, memory returns 32'h20040020 at 0x00400000 -> after edge 1: IF_ID_Instruction=32'h20040020, IF_ID_PCPlus4=0x00400004, Valid=1, IMemAddress=0x00400004, FetchCount=1.
REQ-030 Stall=1 for 3 cycles at PC=0x00400008 -> IMemAddress, IF/ID and FetchCount unchanged for 3 edges; advance resumes on the 4th.
REQ-031 Redirect=1, RedirectPC=0x00400029, Stall=1, same cycle -> next edge: PC=0x00400028, Valid=0, IF_ID_Instruction=NOP, FetchCount unchanged.
REQ-032 Flush=1 and Stall=1 at PC=0x00400010 -> next edge: PC=0x00400014, Valid=0.
REQ-033 Redirect to 0xFFFFFFFC, then one advance -> IMemAddress=0x00000000, IF_ID_PCPlus4=0x00000000, Valid=1.
REQ-034 Assert reset=0 between clock edges during a stall -> outputs at reset values immediately, without a clock edge; after release, first fetch from 0x00400000.
